down_counter: RTL and testbench

DOWN_COUNTER -- requirements
Module: down_counter

---
 rtl/down_counter_pkg.sv | 18 +
 rtl/down_counter_presc.sv | 35 +++
 rtl/down_counter.sv | 101 ++++++++++
 tb/tb_down_counter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/down_counter_pkg.sv
`default_nettype none
// ============================================================================
// down_counter_pkg : shared state encoding and default sizes for down_counter
// Revision: 1.0
// ============================================================================
package down_counter_pkg;

  localparam int DEFAULT_WIDTH       = 32;
  localparam int DEFAULT_PRESC_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/down_counter_presc.sv
`default_nettype none
// ============================================================================
// down_counter_presc : prescaler, one tick every presc+1 enabled cycles
// Revision: 1.0
// ============================================================================
module down_counter_presc
  import down_counter_pkg::*;
#(
  parameter int PRESC_WIDTH = DEFAULT_PRESC_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   en,
  input  logic [PRESC_WIDTH-1:0] presc,
  output logic                   tick
);

  logic [PRESC_WIDTH-1:0] presc_cnt;

  // Equality compare only: if presc drops below presc_cnt the counter wraps
  assign tick = en && (presc_cnt == presc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_cnt <= '0;
    end else if (clr || tick) begin
      presc_cnt <= '0;
    end else if (en) begin
      presc_cnt <= presc_cnt + PRESC_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// ============================================================================
// down_counter : prescaled down counter with one-shot / periodic reload
// Revision: 1.0
// ============================================================================
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int PRESC_WIDTH = DEFAULT_PRESC_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_val,
  input  logic                   periodic,
  input  logic [PRESC_WIDTH-1:0] presc,
  output logic [WIDTH-1:0]       q,
  output logic                   tc,
  output logic                   running,
  output logic                   expired,
  output logic                   zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] reload, reload_n, q_n;
  logic             tc_n;
  logic             presc_en;
  logic             tick;

  assign presc_en = en && (state == ST_RUN);

  down_counter_presc #(
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .en    (presc_en),
    .presc (presc),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      q       <= '0;
      reload  <= '0;
      tc      <= 1'b0;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      q       <= q_n;
      reload  <= reload_n;
      tc      <= tc_n;
      running <= (state_n == ST_RUN);
      expired <= (state_n == ST_EXPIRED);
    end
  end

  // Load wins over any coincident tick and ignores en
  always_comb begin
    state_n  = state;
    q_n      = q;
    reload_n = reload;
    tc_n     = 1'b0;
    if (load) begin
      q_n      = load_val;
      reload_n = load_val;
      state_n  = (load_val != '0) ? ST_RUN : ST_IDLE;
    end else begin
      case (state)
        ST_RUN: begin
          if (tick) begin
            if (q > ONE) begin
              q_n = q - ONE;
            end else if (q == ONE) begin
              tc_n = 1'b1;
              if (periodic) begin
                q_n = reload;
              end else begin
                q_n     = '0;
                state_n = ST_EXPIRED;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign zero = (q == '0);

endmodule
`default_nettype wire

// File: tb/tb_down_counter.sv
`default_nettype none
// ============================================================================
// tb_down_counter : directed self-checking bench for down_counter (WIDTH = 8)
// Revision: 1.0
// ============================================================================
module tb_down_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [7:0] load_val;
  logic       periodic;
  logic [7:0] presc;
  logic [7:0] q;
  logic       tc;
  logic       running;
  logic       expired;
  logic       zero;

  int n_tests = 0;
  int n_fail  = 0;

  down_counter #(
    .WIDTH       (8),
    .PRESC_WIDTH (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .periodic (periodic),
    .presc    (presc),
    .q        (q),
    .tc       (tc),
    .running  (running),
    .expired  (expired),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    step();
    load     = 1'b0;
  endtask

  task automatic check_flags(input string tag, input int eq, input int etc,
                             input int erun, input int eexp);
    check({tag, "_q"}, int'(q), eq);
    check({tag, "_tc"}, int'(tc), etc);
    check({tag, "_running"}, int'(running), erun);
    check({tag, "_expired"}, int'(expired), eexp);
    check({tag, "_zero"}, int'(zero), (eq == 0) ? 1 : 0);
  endtask

  initial begin
    int pq[7];
    int ptc[7];
    int oq[13];

    reset    = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    load_val = 8'd0;
    periodic = 1'b0;
    presc    = 8'd0;
    #1 reset = 1'b1;
    #2;
    check_flags("reset", 0, 0, 0, 0);
    step();
    reset = 1'b0;
    step();
    check_flags("idle_after_reset", 0, 0, 0, 0);

    // Periodic: 3,2,1,3,2,1 with tc on each reload
    en = 1'b1; periodic = 1'b1; presc = 8'd0;
    do_load(8'd3);
    check_flags("per_load", 3, 0, 1, 0);
    pq  = '{2, 1, 3, 2, 1, 3, 2};
    ptc = '{0, 0, 1, 0, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      step();
      check_flags($sformatf("per_%0d", i), pq[i], ptc[i], 1, 0);
    end
    // Clearing periodic makes the next terminal count one-shot
    periodic = 1'b0;
    step();
    check_flags("per_clr_q1", 1, 0, 1, 0);
    step();
    check_flags("per_clr_term", 0, 1, 0, 1);
    step();
    check_flags("per_clr_after", 0, 0, 0, 1);

    // One-shot, presc = 2
    presc = 8'd2;
    do_load(8'd4);
    check_flags("os_load", 4, 0, 1, 0);
    oq = '{4, 4, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0};
    for (int i = 0; i < 13; i++) begin
      step();
      check_flags($sformatf("os_%0d", i + 1), oq[i],
                  (i == 11) ? 1 : 0, (i >= 11) ? 0 : 1, (i >= 11) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      check_flags($sformatf("os_hold_%0d", i), 0, 0, 0, 1);
    end

    // Pause at q = 7 with prescaler phase 1
    do_load(8'd9);
    for (int i = 0; i < 7; i++) step();
    check_flags("pause_pre", 7, 0, 1, 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_flags($sformatf("pause_%0d", i), 7, 0, 1, 0);
    end
    en = 1'b1;
    step();
    check_flags("resume_1", 7, 0, 1, 0);
    step();
    check_flags("resume_2", 6, 0, 1, 0);

    // Load coincident with the q = 1 tick
    presc = 8'd1; periodic = 1'b1;
    do_load(8'd2);
    step(); step();
    check_flags("col_q1", 1, 0, 1, 0);
    step();
    load = 1'b1; load_val = 8'd9;
    step();
    load = 1'b0;
    check_flags("col_load", 9, 0, 1, 0);
    step();
    check_flags("col_next", 9, 0, 1, 0);
    step();
    check_flags("col_tick", 8, 0, 1, 0);

    // Load of zero goes to IDLE and stays there
    do_load(8'd0);
    check_flags("load0", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_flags($sformatf("load0_hold_%0d", i), 0, 0, 0, 0);
    end

    // Asynchronous reset mid-count
    presc = 8'd0; periodic = 1'b0;
    do_load(8'd5);
    check_flags("rst_pre", 5, 0, 1, 0);
    #3 reset = 1'b1;
    #1;
    check_flags("rst_async", 0, 0, 0, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_flags($sformatf("rst_after_%0d", i), 0, 0, 0, 0);
    end
    do_load(8'd2);
    check_flags("rst_reload", 2, 0, 1, 0);

    // Full 8-bit period in periodic mode
    periodic = 1'b1;
    do_load(8'd255);
    check_flags("wrap_load", 255, 0, 1, 0);
    for (int i = 1; i <= 510; i++) begin
      step();
      check($sformatf("wrap_q_%0d", i), int'(q), 255 - (i % 255));
      check($sformatf("wrap_tc_%0d", i), int'(tc), (i % 255 == 0) ? 1 : 0);
    end
    check("wrap_running", int'(running), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
